// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types, widths and wrap-step helper for the alarm bank
package alarm_pkg;

  localparam int HOUR_W           = 5;
  localparam int MIN_W            = 6;
  localparam int HOUR_MAX_DEFAULT = 23;
  localparam int MIN_MAX_DEFAULT  = 59;

  typedef enum logic [2:0] {
    S_SEL     = 3'd0,
    S_HOURS   = 3'd1,
    S_MINUTES = 3'd2,
    S_ENABLE  = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  // One step up or down with wrap between 0 and max_val.
  function automatic logic [5:0] wrap_step(input logic [5:0] value,
                                           input logic [5:0] max_val,
                                           input logic       up);
    if (up) return (value >= max_val) ? 6'd0 : value + 6'd1;
    else    return (value == 6'd0) ? max_val : value - 6'd1;
  endfunction

endpackage

// File: rtl/alarm_match.sv
// rtl/alarm_match.sv - combinational compare of all slots against the current time
module alarm_match
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic [NUM_ALARMS-1:0][HOUR_W-1:0] slot_h,
  input  logic [NUM_ALARMS-1:0][MIN_W-1:0]  slot_m,
  input  logic [NUM_ALARMS-1:0]             slot_en,
  input  logic [HOUR_W-1:0]                 cur_hours,
  input  logic [MIN_W-1:0]                  cur_minutes,
  output logic [NUM_ALARMS-1:0]             match,
  output logic                              any_match,
  output logic [IDX_W-1:0]                  low_idx
);

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      match[i] = slot_en[i] && (slot_h[i] == cur_hours) && (slot_m[i] == cur_minutes);
  end

  assign any_match = |match;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (match[i]) low_idx = IDX_W'(i);
  end

endmodule

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - multi-slot alarm store with button edit FSM and latched ring
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  parameter int HOUR_MAX   = HOUR_MAX_DEFAULT,
  parameter int MIN_MAX    = MIN_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_alarm_en,
  input  logic                  mode_button,
  input  logic                  inc_button,
  input  logic                  dec_button,
  input  logic                  dismiss_button,
  input  logic [HOUR_W-1:0]     cur_hours,
  input  logic [MIN_W-1:0]      cur_minutes,
  input  logic                  minute_tick,
  output logic [IDX_W-1:0]      sel_idx,
  output logic [HOUR_W-1:0]     o_hours,
  output logic [MIN_W-1:0]      o_minutes,
  output logic                  o_edit_en,
  output logic [NUM_ALARMS-1:0] o_alarm_en,
  output logic                  ack_flag,
  output logic                  ring,
  output logic [IDX_W-1:0]      ring_idx
);

  logic [NUM_ALARMS-1:0][HOUR_W-1:0] slot_h;
  logic [NUM_ALARMS-1:0][MIN_W-1:0]  slot_m;
  logic [NUM_ALARMS-1:0]             slot_en;

  state_t              state;
  logic [HOUR_W-1:0]   shadow_h;
  logic [MIN_W-1:0]    shadow_m;
  logic                shadow_en;

  logic                step_any;
  logic [5:0]          sel_next;
  logic [5:0]          h_next;
  logic [5:0]          m_next;

  logic [NUM_ALARMS-1:0] match_vec;
  logic                  any_match;
  logic [IDX_W-1:0]      match_idx;
  logic                  unused_match;

  // inc and dec pressed together cancel out.
  assign step_any = inc_button ^ dec_button;
  assign sel_next = wrap_step(6'(sel_idx), 6'(NUM_ALARMS - 1), inc_button);
  assign h_next   = wrap_step(6'(shadow_h), 6'(HOUR_MAX), inc_button);
  assign m_next   = wrap_step(shadow_m, 6'(MIN_MAX), inc_button);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SEL;
      sel_idx   <= '0;
      shadow_h  <= '0;
      shadow_m  <= '0;
      shadow_en <= 1'b0;
      slot_h    <= '0;
      slot_m    <= '0;
      slot_en   <= '0;
    end else if (!set_alarm_en) begin
      state <= S_SEL;
    end else begin
      unique case (state)
        S_SEL: begin
          if (mode_button) begin
            shadow_h  <= slot_h[sel_idx];
            shadow_m  <= slot_m[sel_idx];
            shadow_en <= slot_en[sel_idx];
            state     <= S_HOURS;
          end else if (step_any) begin
            sel_idx <= sel_next[IDX_W-1:0];
          end
        end
        S_HOURS: begin
          if (mode_button)   state    <= S_MINUTES;
          else if (step_any) shadow_h <= h_next[HOUR_W-1:0];
        end
        S_MINUTES: begin
          if (mode_button)   state    <= S_ENABLE;
          else if (step_any) shadow_m <= m_next;
        end
        S_ENABLE: begin
          if (mode_button)   state     <= S_COMMIT;
          else if (step_any) shadow_en <= ~shadow_en;
        end
        S_COMMIT: begin
          slot_h[sel_idx]  <= shadow_h;
          slot_m[sel_idx]  <= shadow_m;
          slot_en[sel_idx] <= shadow_en;
          state            <= S_SEL;
        end
        default: state <= S_SEL;
      endcase
    end
  end

  assign ack_flag   = (state == S_COMMIT) && set_alarm_en;
  assign o_alarm_en = slot_en;

  always_comb begin
    o_hours   = slot_h[sel_idx];
    o_minutes = slot_m[sel_idx];
    o_edit_en = slot_en[sel_idx];
    if (state == S_HOURS || state == S_MINUTES || state == S_ENABLE) begin
      o_hours   = shadow_h;
      o_minutes = shadow_m;
      o_edit_en = shadow_en;
    end
  end

  alarm_match #(
    .NUM_ALARMS (NUM_ALARMS),
    .IDX_W      (IDX_W)
  ) u_match (
    .slot_h      (slot_h),
    .slot_m      (slot_m),
    .slot_en     (slot_en),
    .cur_hours   (cur_hours),
    .cur_minutes (cur_minutes),
    .match       (match_vec),
    .any_match   (any_match),
    .low_idx     (match_idx)
  );

  assign unused_match = ^match_vec;

  // A match outranks a dismiss arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring     <= 1'b0;
      ring_idx <= '0;
    end else if (minute_tick && any_match) begin
      ring     <= 1'b1;
      ring_idx <= match_idx;
    end else if (dismiss_button) begin
      ring <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - randomized and directed self-checking bench for alarm_bank
module tb_alarm_bank;

  localparam int NUM = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           set_alarm_en, mode_button, inc_button, dec_button, dismiss_button;
  logic [4:0]     cur_hours;
  logic [5:0]     cur_minutes;
  logic           minute_tick;
  logic [1:0]     sel_idx;
  logic [4:0]     o_hours;
  logic [5:0]     o_minutes;
  logic           o_edit_en;
  logic [NUM-1:0] o_alarm_en;
  logic           ack_flag;
  logic           ring;
  logic [1:0]     ring_idx;

  alarm_bank #(.NUM_ALARMS(NUM)) dut (
    .clk(clk), .rst(rst), .set_alarm_en(set_alarm_en), .mode_button(mode_button),
    .inc_button(inc_button), .dec_button(dec_button), .dismiss_button(dismiss_button),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .minute_tick(minute_tick),
    .sel_idx(sel_idx), .o_hours(o_hours), .o_minutes(o_minutes), .o_edit_en(o_edit_en),
    .o_alarm_en(o_alarm_en), .ack_flag(ack_flag), .ring(ring), .ring_idx(ring_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stage 0=select 1=hours 2=minutes 3=enable 4=commit
  int m_h[NUM], m_m[NUM], m_en[NUM];
  int m_sel, m_stage, s_h, s_m, s_en, m_ring, m_ridx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        m_h[i] <= 0; m_m[i] <= 0; m_en[i] <= 0;
      end
      m_sel <= 0; m_stage <= 0; s_h <= 0; s_m <= 0; s_en <= 0;
      m_ring <= 0; m_ridx <= 0;
    end else begin : model_step
      automatic int hit = -1;
      automatic int d = (inc_button && !dec_button) ? 1 : (dec_button && !inc_button) ? -1 : 0;
      if (minute_tick)
        for (int i = 0; i < NUM; i++)
          if (hit < 0 && m_en[i] == 1 && m_h[i] == int'(cur_hours) && m_m[i] == int'(cur_minutes))
            hit = i;
      if (hit >= 0) begin
        m_ring <= 1; m_ridx <= hit;
      end else if (dismiss_button) begin
        m_ring <= 0;
      end
      if (!set_alarm_en) m_stage <= 0;
      else case (m_stage)
        0: if (mode_button) begin
             s_h <= m_h[m_sel]; s_m <= m_m[m_sel]; s_en <= m_en[m_sel]; m_stage <= 1;
           end else m_sel <= (m_sel + d + NUM) % NUM;
        1: if (mode_button) m_stage <= 2; else s_h <= (s_h + d + 24) % 24;
        2: if (mode_button) m_stage <= 3; else s_m <= (s_m + d + 60) % 60;
        3: if (mode_button) m_stage <= 4; else if (d != 0) s_en <= 1 - s_en;
        default: begin
          m_h[m_sel] <= s_h; m_m[m_sel] <= s_m; m_en[m_sel] <= s_en; m_stage <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin : compare
      automatic int eh = m_h[m_sel];
      automatic int em = m_m[m_sel];
      automatic int ee = m_en[m_sel];
      automatic int ea = 0;
      if (m_stage >= 1 && m_stage <= 3) begin
        eh = s_h; em = s_m; ee = s_en;
      end
      for (int i = 0; i < NUM; i++) ea |= m_en[i] << i;
      check("sel_idx", int'(sel_idx), m_sel);
      check("o_hours", int'(o_hours), eh);
      check("o_minutes", int'(o_minutes), em);
      check("o_edit_en", int'(o_edit_en), ee);
      check("o_alarm_en", int'(o_alarm_en), ea);
      check("ack_flag", int'(ack_flag), (m_stage == 4 && set_alarm_en) ? 1 : 0);
      check("ring", int'(ring), m_ring);
      check("ring_idx", int'(ring_idx), m_ridx);
    end
  end

  task automatic step(input bit en, input bit md, input bit in, input bit de,
                      input bit ds, input bit tk);
    set_alarm_en = en; mode_button = md; inc_button = in; dec_button = de;
    dismiss_button = ds; minute_tick = tk;
    @(posedge clk); #1;
  endtask

  task automatic idle();    step(1, 0, 0, 0, 0, 0); endtask
  task automatic p_mode();  step(1, 1, 0, 0, 0, 0); endtask
  task automatic p_inc();   step(1, 0, 1, 0, 0, 0); endtask
  task automatic p_dec();   step(1, 0, 0, 1, 0, 0); endtask

  task automatic program_slot(input int idx, input int h, input int m, input int en);
    for (int k = 0; k < NUM && m_sel != idx; k++) p_inc();
    p_mode();
    repeat ((h - s_h + 24) % 24) p_inc();
    p_mode();
    repeat ((m - s_m + 60) % 60) p_inc();
    p_mode();
    if (s_en != en) p_inc();
    p_mode();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    set_alarm_en = 0; mode_button = 0; inc_button = 0; dec_button = 0;
    dismiss_button = 0; minute_tick = 0; cur_hours = 5'd12; cur_minutes = 6'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    check("reset sel_idx", int'(sel_idx), 0);
    check("reset ring", int'(ring), 0);
    check("reset o_alarm_en", int'(o_alarm_en), 0);

    // slot0 -> 03:59 enabled
    p_mode(); repeat (3) p_inc(); p_mode(); p_dec(); p_mode(); p_inc(); p_mode();
    check("commit ack pulse", int'(ack_flag), 1);
    idle();
    check("ack drops", int'(ack_flag), 0);
    check("slot0 hours", int'(o_hours), 3);
    check("slot0 minutes", int'(o_minutes), 59);
    check("slot0 alarm_en", int'(o_alarm_en), 1);

    // hours and minutes wrap
    p_mode(); repeat (4) p_dec();
    check("hours dec wrap", int'(o_hours), 23);
    p_inc();  check("hours inc wrap", int'(o_hours), 0);
    p_dec();  check("hours dec back", int'(o_hours), 23);
    p_mode(); p_inc();
    check("minutes inc wrap", int'(o_minutes), 0);
    step(0, 0, 0, 0, 0, 0);
    check("abort keeps slot0 h", int'(o_hours), 3);
    idle();

    // select wrap and aborted edit of slot2
    p_dec(); check("sel dec wrap", int'(sel_idx), 3);
    p_inc(); check("sel inc wrap", int'(sel_idx), 0);
    p_inc(); p_inc(); p_mode(); p_inc(); p_mode(); p_inc();
    step(0, 0, 0, 0, 0, 0);
    check("abort no ack", int'(ack_flag), 0);
    check("slot2 untouched", int'(o_minutes), 0);
    idle();

    // ring on lowest matching slot, then dismiss
    program_slot(1, 7, 30, 1);
    program_slot(3, 7, 30, 1);
    cur_hours = 5'd7; cur_minutes = 6'd30;
    step(1, 0, 0, 0, 0, 1);
    check("ring set", int'(ring), 1);
    check("ring lowest idx", int'(ring_idx), 1);
    step(1, 0, 0, 0, 1, 0);
    check("ring dismissed", int'(ring), 0);

    // disabled slot never rings; match beats dismiss
    program_slot(0, 6, 0, 0);
    cur_hours = 5'd6; cur_minutes = 6'd0;
    step(1, 0, 0, 0, 0, 1);
    check("disabled no ring", int'(ring), 0);
    cur_hours = 5'd7; cur_minutes = 6'd30;
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    check("match beats dismiss", int'(ring), 1);

    // async reset mid-edit while ringing
    p_inc(); p_mode(); p_mode(); p_mode();
    #3 rst = 1'b1;
    #1;
    check("async ring", int'(ring), 0);
    check("async sel_idx", int'(sel_idx), 0);
    check("async o_alarm_en", int'(o_alarm_en), 0);
    check("async o_hours", int'(o_hours), 0);
    @(posedge clk); #1 rst = 1'b0;

    // randomized phase
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(1, 0) == 1) begin : near_slot
        automatic int j = $urandom_range(NUM - 1, 0);
        cur_hours = 5'(m_h[j]); cur_minutes = 6'(m_m[j]);
      end else begin
        cur_hours = 5'($urandom_range(31, 0)); cur_minutes = 6'($urandom_range(63, 0));
      end
      step($urandom_range(19, 0) != 0, $urandom_range(5, 0) == 0, $urandom_range(3, 0) == 0,
           $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0);
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
